fft_twiddle_stream_scheduler: RTL
=================================

// Module: fft_twiddle_stream_scheduler
// PURPOSE
//  Sequences twiddle factors for an iterative radix-2 Cooley-Tukey FFT that reuses one butterfly unit.
//  Captures a full sine table on a start handshake, then streams one twiddle pair per beat.
//  Beat order: stage 0..S-1 (S = log2(SIZE_FFT)); within each stage, butterfly slot j = 0..SIZE_FFT/2-1.
//  Sits between the sine ROM and the butterfly datapath controller.
// PARAMETERS
//  BIT_WIDTH   16  width of each sine sample and twiddle component, two's complement
//  DECIMAL_PT  8   fixed-point fraction bits; pass-through only, no arithmetic depends on it
//  SIZE_FFT    8   FFT points; power of two, >= 4
// PORTS
//  clk           in   1                        clock
//  reset         in   1                        synchronous, active-high
//  recv_val      in   1                        start request; table on sine_wave_in is valid
//  recv_rdy      out  1                        scheduler idle and able to accept a table
//  sine_wave_in  in   BIT_WIDTH x SIZE_FFT     sine_wave_in[k] = sin(2*pi*k/N)
//  send_val      out  1                        twiddle beat valid
//  send_rdy      in   1                        consumer accepts the beat
//  twiddle_real  out  BIT_WIDTH                cos component of the current beat
//  twiddle_imag  out  BIT_WIDTH                -sin component of the current beat
//  stage         out  $clog2(log2 N)+1         stage index s of the current beat
//  slot          out  $clog2(N/2)              butterfly slot j of the current beat
//  last_in_stage out  1                        j == N/2-1
//  last          out  1                        final beat of the whole transform
// BEHAVIOUR
//  - Clock and reset: single clock. Reset is synchronous and active-high.
//  - Reset state: FSM in IDLE; recv_rdy=1; send_val=0.
//  - Reset data values: twiddle_real, twiddle_imag, stage, slot, last_in_stage and last are all 0.
//  - FSM states:
//      IDLE: recv_rdy=1. On recv_val&&recv_rdy, register all N sine samples, clear stage and slot, go to SEND.
//      SEND: send_val=1, recv_rdy=0. On send_val&&send_rdy, advance the counters.
//        - If slot < N/2-1: slot++.
//        - Otherwise: slot=0 and stage++.
//        - On a handshake with last=1: go to IDLE.
//  - Latency: the first beat is valid the cycle after the start handshake.
//    One beat per cycle while send_rdy stays high; total S*N/2 beats.
//  - Stall: while send_val&&!send_rdy, every output holds stable.
//  - The captured table is used for the whole run. sine_wave_in may change freely after the start handshake.
//  - Twiddle mapping, per beat:
//      m   = j mod 2^s
//      idx = m * N / 2^(s+1)
//      twiddle_real = tbl[(idx + N/4) mod N]
//      twiddle_imag = -tbl[idx]
//  - Outputs are registered: the mapping for the next beat is computed and loaded on the advancing edge.
//  - Negation is two's complement at BIT_WIDTH with wrap; -(min) = min. No saturation.
//  - last_in_stage and last are combinational from the registered stage and slot.
//  - recv_val during SEND is ignored (recv_rdy=0). No queuing.
//    After the final beat the FSM returns to IDLE for one cycle before it accepts again.
//  - Reset mid-run: the beat stream aborts immediately, with no trailing beat, and the FSM returns to IDLE.
//  - send_rdy asserted without send_val has no effect.
// STRUCTURE
//  - Shared package fft_pkg holds:
//      function clog2_stages(N) returning log2 N;
//      the state typedef enum {IDLE, SEND}.
//  - One sub-module, fft_twiddle_index_lookup. It is combinational: (table, s, j) -> (real, imag).
//    It implements the mapping above and is instanced once on the next-beat counter values.
//  - Counters, FSM, table register and output registers live in the top module.
// TESTING (BIT_WIDTH=8, DECIMAL_PT=6, N=8, table = [0,45,64,45,0,-45,-64,-45])
//  - Start, send_rdy held 1 -> 12 consecutive beats.
//    Stage 0: (64,0) x4.
//    Stage 1: (64,0),(0,-64),(64,0),(0,-64).
//    Stage 2: (64,0),(45,-45),(0,-64),(-45,-45).
//    last_in_stage on slot 3; last on beat 12.
//  - Reset value: reset 1 cycle -> recv_rdy=1, send_val=0, all data outputs 0.
//  - Stall: deassert send_rdy on beat 6 for 3 cycles -> beat 6 = (0,-64), s=1, j=1, held unchanged; stream resumes.
//  - Table change: change sine_wave_in to all -128 one cycle after start -> stream identical to the first test.
//    Then start with the all -128 table -> every beat is (-128,-128), exercising the negate wrap.
//  - Busy start: recv_val held high throughout -> exactly one run of 12 beats.
//    recv_rdy=0 during SEND; second start accepted in the IDLE cycle after last.
//  - Reset mid-run: assert reset during beat 7 -> next cycle send_val=0, recv_rdy=1.
//    A new run then starts from s=0, j=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT twiddle scheduler slice.
package fft_pkg;

    // Scheduler states: waiting for a table, or streaming twiddle beats.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of radix-2 stages for an n-point transform (log2 n, n a power of two).
    function automatic int clog2_stages(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_index_lookup.sv
// Combinational twiddle mapping: (table, stage s, slot j) -> (cos, -sin).
// idx = (j mod 2^s) * N / 2^(s+1); real = tbl[idx + N/4], imag = -tbl[idx].
module fft_twiddle_index_lookup
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int SIZE_FFT  = 8,
    parameter int SW        = 3,
    parameter int JW        = 2
) (
    input  logic [BIT_WIDTH-1:0] tbl [SIZE_FFT],
    input  logic [SW-1:0]        s,
    input  logic [JW-1:0]        j,
    output logic [BIT_WIDTH-1:0] twiddle_real,
    output logic [BIT_WIDTH-1:0] twiddle_imag
);

    localparam int LOGN = clog2_stages(SIZE_FFT);

    logic [LOGN-1:0] j_ext;
    logic [LOGN-1:0] mask;
    logic [LOGN-1:0] m;
    logic [LOGN-1:0] idx;
    logic [LOGN-1:0] ridx;

    // The scale by N/2^(s+1) is a shift; the cos lookup is a quarter-turn
    // offset into the same sine table, wrapping naturally at LOGN bits.
    always_comb begin
        j_ext = {1'b0, j};
        mask  = ~({LOGN{1'b1}} << s);
        m     = j_ext & mask;
        if (s < SW'(LOGN)) begin
            idx = m << (SW'(LOGN - 1) - s);
        end else begin
            idx = m >> (s - SW'(LOGN - 1));
        end
        ridx         = idx + LOGN'(SIZE_FFT / 4);
        twiddle_real = tbl[ridx];
        twiddle_imag = -tbl[idx];
    end

endmodule

// File: rtl/fft_twiddle_stream_scheduler.sv
// Captures a sine table on a start handshake and streams one registered
// twiddle pair per beat, stage-major then butterfly-slot order.
module fft_twiddle_stream_scheduler
    import fft_pkg::*;
#(
    parameter int  BIT_WIDTH  = 16,
    parameter int  DECIMAL_PT = 8,
    parameter int  SIZE_FFT   = 8,
    localparam int STAGES     = clog2_stages(SIZE_FFT),
    localparam int SW         = $clog2(STAGES) + 1,
    localparam int JW         = $clog2(SIZE_FFT / 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] sine_wave_in [SIZE_FFT],
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] twiddle_real,
    output logic [BIT_WIDTH-1:0] twiddle_imag,
    output logic [SW-1:0]        stage,
    output logic [JW-1:0]        slot,
    output logic                 last_in_stage,
    output logic                 last
);

    localparam int LAST_SLOT = SIZE_FFT / 2 - 1;

    // The fraction position is carried for the consumer only; nothing here depends on it.
    if (DECIMAL_PT >= BIT_WIDTH) begin : g_frac_wider_than_word
    end

    state_t               state_reg, state_next;
    logic [SW-1:0]        stage_reg, stage_next;
    logic [JW-1:0]        slot_reg, slot_next;
    logic [BIT_WIDTH-1:0] tbl_reg [SIZE_FFT];
    logic [BIT_WIDTH-1:0] tbl_src [SIZE_FFT];
    logic [BIT_WIDTH-1:0] real_reg, imag_reg;
    logic [BIT_WIDTH-1:0] lk_real, lk_imag;
    logic                 start, advance, is_last;

    // On the start edge the table is not registered yet, so the first beat
    // is looked up straight from the input table.
    for (genvar gi = 0; gi < SIZE_FFT; gi++) begin : g_tbl_src
        assign tbl_src[gi] = start ? sine_wave_in[gi] : tbl_reg[gi];
    end

    fft_twiddle_index_lookup #(
        .BIT_WIDTH (BIT_WIDTH),
        .SIZE_FFT  (SIZE_FFT),
        .SW        (SW),
        .JW        (JW)
    ) u_lookup (
        .tbl          (tbl_src),
        .s            (stage_next),
        .j            (slot_next),
        .twiddle_real (lk_real),
        .twiddle_imag (lk_imag)
    );

    assign is_last = (stage_reg == SW'(STAGES - 1)) && (slot_reg == JW'(LAST_SLOT));

    // Next-state, next-beat counters and handshake outputs.
    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        slot_next  = slot_reg;
        start      = 1'b0;
        advance    = 1'b0;
        recv_rdy   = 1'b0;
        send_val   = 1'b0;
        case (state_reg)
            IDLE: begin
                recv_rdy = 1'b1;
                if (recv_val) begin
                    start      = 1'b1;
                    stage_next = '0;
                    slot_next  = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                send_val = 1'b1;
                if (send_rdy) begin
                    advance = 1'b1;
                    if (slot_reg == JW'(LAST_SLOT)) begin
                        slot_next  = '0;
                        stage_next = stage_reg + SW'(1);
                    end else begin
                        slot_next = slot_reg + JW'(1);
                    end
                    if (is_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and output pair update only on start or an accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            stage_reg <= '0;
            slot_reg  <= '0;
            real_reg  <= '0;
            imag_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (start || advance) begin
                stage_reg <= stage_next;
                slot_reg  <= slot_next;
                real_reg  <= lk_real;
                imag_reg  <= lk_imag;
            end
        end
    end

    // Table snapshot taken on the start handshake and held for the whole run.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int k = 0; k < SIZE_FFT; k++) begin
                tbl_reg[k] <= sine_wave_in[k];
            end
        end
    end

    assign twiddle_real  = real_reg;
    assign twiddle_imag  = imag_reg;
    assign stage         = stage_reg;
    assign slot          = slot_reg;
    assign last_in_stage = (slot_reg == JW'(LAST_SLOT));
    assign last          = is_last;

endmodule
